// File: rtl/imem_uart_loader.sv
// Instruction-RAM loader: takes a length-prefixed program image from UART bytes and writes 32-bit words from address 0.
// Build option `IMEM_LOADER_CHECKSUM_EN appends a mod-256 checksum byte over the data bytes to the frame.
module imem_uart_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t          state;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [23:0]     asm_word;
  logic [1:0]      byte_idx;
  logic [TW-1:0]   tcnt;
  logic            last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum;
`endif

  logic [15:0] rx_len;
  logic [31:0] word_in;
  logic        last_in;
  assign rx_len  = {len_hi, rx_data};
  assign word_in = {asm_word, rx_data};
  assign last_in = (16'(words_loaded) + 16'd1) == len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len_hi       <= '0;
      len          <= '0;
      asm_word     <= '0;
      byte_idx     <= '0;
      tcnt         <= '0;
      last_word    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      // The address counter advances on the edge after each write strobe.
      if (mem_we) words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_HI;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            mem_addr     <= '0;
            byte_idx     <= '0;
            tcnt         <= '0;
            last_word    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
          end
        end
        default: begin
          // A byte in the final cycle beats the timeout.
          if (rx_valid) begin
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + {{(TW-1){1'b0}}, 1'b1};
            if (tcnt == TW'(TIMEOUT_CYC - 2)) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
          case (state)
            LEN_HI: if (rx_valid) begin
              len_hi <= rx_data;
              state  <= LEN_LO;
            end
            LEN_LO: if (rx_valid) begin
              len <= rx_len;
              if (rx_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state    <= DONE;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
`endif
              end else if ({1'b0, rx_len} > 17'(1 << ADDR_W)) begin
                state <= ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
            DATA: begin
              if (rx_valid && !last_word) begin
                asm_word <= word_in[23:0];
                byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum      <= sum + rx_data;
`endif
                if (byte_idx == 2'd3) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= word_in;
                  mem_addr  <= words_loaded[ADDR_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                  if (last_in) state <= CHK;
`else
                  if (last_in) last_word <= 1'b1;
`endif
                end
              end
              // Release the CPU only once the final write has landed.
              if (last_word) begin
                state    <= DONE;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
              end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (rx_valid) begin
              if (rx_data == sum) begin
                state    <= DONE;
                busy     <= 1'b0;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= ERR;
                busy  <= 1'b0;
                error <= 1'b1;
              end
            end
`endif
            default: ;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: scoreboard of expected RAM writes plus status checks.
// Honours `IMEM_LOADER_CHECKSUM_EN by appending checksum bytes and running the checksum cases.
module tb_imem_uart_loader;
  localparam int ADDR_W      = 8;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int chk_frames = 0;
  int start_at = -1;
  logic [7:0] frame[$];
  logic [ADDR_W+31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) check("spurious_we", 64'(mem_we), 64'd0);
      else check("ram_write", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input bit add_chk);
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'h00;
    w = 32'h0;
    if (add_chk) chk_frames++;
    for (int i = 0; i < frame.size(); i++) begin
      if (i >= 2) begin
        s = s + frame[i];
        w = {w[23:0], frame[i]};
        if ((i - 2) % 4 == 3) exp_q.push_back({ADDR_W'((i - 2) / 4), w});
      end
      send_byte(frame[i]);
      if (i + 1 == start_at) start = 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (add_chk) send_byte(s);
`endif
  endtask

  task automatic check_status(input string tag, input logic b, input logic h, input logic d,
                              input logic e, input int wl);
    check({tag, "_busy"}, 64'(busy), 64'(b));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(h));
    check({tag, "_done"}, 64'(done), 64'(d));
    check({tag, "_error"}, 64'(error), 64'(e));
    check({tag, "_words"}, 64'(words_loaded), 64'(wl));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_loaded}), 64'd0);
    reset = 1'b0;

    // normal two-word load, with a start pulse mid-frame that must be ignored
    pulse_start();
    check_status("armed", 1, 1, 0, 0, 0);
    frame = '{8'h00, 8'h02, 8'h3C, 8'h19, 8'h40, 8'h00, 8'h8F, 8'h31, 8'h00, 8'h08};
    start_at = 5;
    send_frame(1'b1);
    start_at = -1;
    repeat (3) @(negedge clk);
    check_status("normal", 0, 0, 1, 0, 2);
    check("normal_last_addr", 64'(mem_addr), 64'd1);

    // bytes while DONE produce no writes
    send_byte(8'h55);
    send_byte(8'hAA);
    repeat (2) @(negedge clk);
    check_status("idle_rx", 0, 0, 1, 0, 2);

    // zero length
    pulse_start();
    frame = '{8'h00, 8'h00};
    send_frame(1'b1);
    repeat (2) @(negedge clk);
    check_status("zero_len", 0, 0, 1, 0, 0);

    // oversize length 257
    pulse_start();
    frame = '{8'h01, 8'h01};
    send_frame(1'b0);
    repeat (2) @(negedge clk);
    check_status("oversize", 0, 1, 0, 1, 0);

    // timeout: error exactly 15 idle cycles after the last byte
    pulse_start();
    check_status("rearm", 1, 1, 0, 0, 0);
    frame = '{8'h00, 8'h01, 8'hAA};
    send_frame(1'b0);
    repeat (TIMEOUT_CYC - 2) @(negedge clk);
    check("timeout_early", 64'(error), 64'd0);
    @(negedge clk);
    check("timeout_hit", 64'(error), 64'd1);
    check_status("timeout", 0, 1, 0, 1, 0);
    pulse_start();
    check("timeout_rearm_error", 64'(error), 64'd0);

    // asynchronous reset after the second data byte
    frame = '{8'h00, 8'h01, 8'h11, 8'h22};
    send_frame(1'b0);
    #2 reset = 1'b1;
    #1 check("reset_mid_load", 64'({mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, words_loaded}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    pulse_start();
    frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(1'b1);
    repeat (3) @(negedge clk);
    check_status("after_reset", 0, 0, 1, 0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    frame = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(1'b0);
    send_byte(8'h0A);
    repeat (2) @(negedge clk);
    check_status("chk_good", 0, 0, 1, 0, 1);
    pulse_start();
    send_frame(1'b0);
    send_byte(8'h0B);
    repeat (2) @(negedge clk);
    check_status("chk_bad", 0, 1, 0, 1, 1);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the instruction memory. It receives a program image byte-by-byte from the UART receiver and writes 32-bit words into the instruction RAM starting at word 0.
- While loading, it holds the CPU core in reset through cpu_hold.
- Sits between the UART RX byte interface and the instruction RAM write port; it replaces the fixed-content instruction store for field reprogramming.

Parameters:
- ADDR_W, 8, word-address width of the instruction RAM; capacity is 2^ADDR_W words (256).
- TIMEOUT_CYC, 1000000, maximum idle clock cycles between received bytes during a load before the load aborts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that arms a load; ignored while busy
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- mem_we  out  1  instruction RAM write enable, one-cycle pulse
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- cpu_hold  out  1  holds the CPU in reset while high
- busy  out  1  load in progress
- done  out  1  level; last load completed successfully
- error  out  1  level; last load aborted
- words_loaded  out  ADDR_W+1  count of words written by the current or last load

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0, including cpu_hold, mem_addr, mem_wdata and words_loaded.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first.
- States: IDLE, LEN_HI, LEN_LO, DATA, [CHK], DONE, ERR.
- IDLE/DONE/ERR + start pulse → LEN_HI:
  - busy=1, cpu_hold=1
  - done=0, error=0
  - words_loaded=0, mem_addr=0
  - byte index=0
  - timeout counter cleared
- LEN_HI + rx_valid → latch the high byte; go to LEN_LO.
- LEN_LO + rx_valid → form N, then:
  - N=0 → DONE.
  - N > 2^ADDR_W → ERR.
  - otherwise → DATA.
- DATA: each rx_valid shifts the byte into the assembly register (first byte lands in [31:24]) and increments the byte index mod 4.
- Write on the 4th byte:
  - On the clock edge that takes the 4th byte: mem_wdata = assembled word, mem_addr = words_loaded[ADDR_W-1:0], mem_we=1 for exactly that one cycle.
  - On the following edge: words_loaded increments.
  - Write latency: mem_we is high the cycle after the 4th rx_valid.
- Leaving DATA: after the Nth word's write, go to DONE, or to CHK when the checksum feature is compiled in.
- DONE: busy=0, cpu_hold=0 (CPU released), done=1.
- ERR: busy=0, error=1, cpu_hold stays 1 so a partial image never runs. Only start or reset leaves ERR.
- Timeout:
  - In LEN_HI, LEN_LO, DATA and CHK, the counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYC-1 → ERR.
  - If rx_valid arrives in the same cycle the counter reaches TIMEOUT_CYC-1, the byte wins and no timeout occurs.
- Unexpected input:
  - start while busy: ignored.
  - rx_valid in IDLE/DONE/ERR: ignored; no writes occur.
- mem_addr holds the last written address between writes. mem_wdata is don't-care when mem_we=0 but must be registered.
- Reset mid-load: immediate return to IDLE; cpu_hold drops to 0; no further writes.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, enter CHK and expect one byte equal to the mod-256 sum of all 4N data bytes (length bytes excluded).
  - Match → DONE; mismatch → ERR.
  - For N=0, CHK still expects byte 0x00.
- Not defined: the CHK state and the sum register are absent; the last data word goes directly to DONE.

Test Plan:
- Normal load: start, then bytes 00 02 3C 19 40 00 8F 31 00 08 → two mem_we pulses: addr 0 data 0x3C194000, then addr 1 data 0x8F310008. Then done=1, cpu_hold=0, words_loaded=2.
- Zero length: start, then 00 00 → DONE with no mem_we, done=1, cpu_hold=0 (with checksum enabled, byte 00 is required first).
- Oversize length: ADDR_W=8, bytes 01 01 (N=257) → ERR, error=1, cpu_hold=1, no writes.
- Timeout: TIMEOUT_CYC=16, start, 00 01 AA, then silence → error=1 exactly 15 idle cycles after the byte AA, no mem_we. A following start re-arms the loader and clears error.
- Reset mid-load: assert reset after the 2nd data byte → all outputs 0 asynchronously. A following full frame with N=1 writes addr 0 correctly.
- Checksum (macro defined): frame 00 01 01 02 03 04 then checksum 0A → DONE. The same frame with checksum 0B → ERR with cpu_hold=1. Word 0x01020304 is written at addr 0 in both cases.
